regfile_mp: RTL and testbench

Parametrised multi-read-port register file for the multicycle MIPS datapath, replacing the fixed 32x32, two-read-port register file. Provides NUM_RD registered read ports, one byte-maskable write port, a hardwired zero register, and write-to-read bypass. A built-in clear sequencer zeroes the whole array after reset or on request. It sits between the instruction-decode stage (addresses) and the ALU operand latches (read data).

---
 rtl/regfile_mp_if.sv | 28 ++
 rtl/regfile_mp.sv | 104 ++++++++++
 tb/tb_regfile_mp.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/regfile_mp_if.sv
// Bus bundle for the multi-read-port register file.
// The master drives addresses and write data; the slave returns read data and busy.
interface regfile_mp_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NUM_RD = 2
);
  logic [NUM_RD*ADDR_W-1:0] rd_addr;
  logic [NUM_RD*DATA_W-1:0] rd_data;
  logic                     wr_en;
  logic [ADDR_W-1:0]        wr_addr;
  logic [DATA_W-1:0]        wr_data;
  logic [DATA_W/8-1:0]      wr_be;
  logic                     clear_req;
  logic                     busy;

  modport master (
    output rd_addr, wr_en, wr_addr,
    output wr_data, wr_be, clear_req,
    input  rd_data, busy
  );

  modport slave (
    input  rd_addr, wr_en, wr_addr,
    input  wr_data, wr_be, clear_req,
    output rd_data, busy
  );
endinterface

// File: rtl/regfile_mp.sv
// Register file: NUM_RD registered read ports, one byte-masked write port,
// hardwired zero entry, write-to-read bypass and a self-clearing sequencer.
module regfile_mp #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NUM_RD = 2
) (
  input logic          clk,
  input logic          rst_n,
  regfile_mp_if.slave  bus
);
  localparam int DEPTH = 2**ADDR_W;
  localparam int NB    = DATA_W/8;

  typedef enum logic {
    S_IDLE,
    S_CLEAR
  } state_t;

  state_t              r_state;
  state_t              w_state_nx;
  logic [ADDR_W-1:0]   r_clr_ptr;
  logic [ADDR_W-1:0]   w_clr_ptr_nx;
  logic                r_busy;
  logic [DATA_W-1:0]   r_mem [DEPTH];
  logic [NUM_RD*DATA_W-1:0] r_rd_data;
  logic [NUM_RD*DATA_W-1:0] w_rd_nx;
  logic [DATA_W-1:0]   w_wr_merged;
  logic                w_wr_fire;

  always_comb begin
    w_state_nx   = r_state;
    w_clr_ptr_nx = r_clr_ptr;
    unique case (r_state)
      S_IDLE: begin
        if (bus.clear_req) begin
          w_state_nx   = S_CLEAR;
          w_clr_ptr_nx = '0;
        end
      end
      S_CLEAR: begin
        w_clr_ptr_nx = r_clr_ptr + 1'b1;
        if (&r_clr_ptr) w_state_nx = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_CLEAR;
      r_clr_ptr <= '0;
      r_busy    <= 1'b1;
    end else begin
      r_state   <= w_state_nx;
      r_clr_ptr <= w_clr_ptr_nx;
      r_busy    <= (w_state_nx == S_CLEAR);
    end
  end

  assign w_wr_fire = bus.wr_en
                   && (r_state == S_IDLE)
                   && (bus.wr_addr != '0);

  always_comb begin
    w_wr_merged = r_mem[bus.wr_addr];
    for (int i = 0; i < NB; i++) begin
      if (bus.wr_be[i])
        w_wr_merged[8*i +: 8] = bus.wr_data[8*i +: 8];
    end
  end

  // A matching write this cycle overrides the array so reads never go stale.
  always_comb begin
    w_rd_nx = '0;
    if (r_state == S_IDLE) begin
      for (int p = 0; p < NUM_RD; p++) begin
        if (bus.rd_addr[p*ADDR_W +: ADDR_W] == '0)
          w_rd_nx[p*DATA_W +: DATA_W] = '0;
        else if (w_wr_fire &&
                 bus.rd_addr[p*ADDR_W +: ADDR_W] == bus.wr_addr)
          w_rd_nx[p*DATA_W +: DATA_W] = w_wr_merged;
        else
          w_rd_nx[p*DATA_W +: DATA_W] =
            r_mem[bus.rd_addr[p*ADDR_W +: ADDR_W]];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_rd_data <= '0;
    else        r_rd_data <= w_rd_nx;
  end

  // The array has no reset; the clear sequencer zeroes it after release.
  always_ff @(posedge clk) begin
    if (r_state == S_CLEAR)
      r_mem[r_clr_ptr] <= '0;
    else if (w_wr_fire)
      r_mem[bus.wr_addr] <= w_wr_merged;
  end

  assign bus.rd_data = r_rd_data;
  assign bus.busy    = r_busy;
endmodule

// File: tb/tb_regfile_mp.sv
// Randomised scoreboard bench for regfile_mp at default and reduced sizes.
// A behavioural model predicts busy/rd_data per edge; monitors compare on negedge.
module tb_regfile_mp;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  regfile_mp_if #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2)) a ();
  regfile_mp_if #(.DATA_W(16), .ADDR_W(3), .NUM_RD(4)) b ();

  regfile_mp #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2)) u_a (
    .clk(clk), .rst_n(rst_n), .bus(a)
  );
  regfile_mp #(.DATA_W(16), .ADDR_W(3), .NUM_RD(4)) u_b (
    .clk(clk), .rst_n(rst_n), .bus(b)
  );

  int n_cmp = 0;
  int n_bad = 0;
  logic [64:0] qA [$];
  logic [64:0] qB [$];
  int clrA = 32;
  int clrB = 8;
  logic [31:0] memA [32];
  logic [15:0] memB [8];

  function automatic logic [31:0] mrg(input logic [31:0] o,
                                      input logic [31:0] d,
                                      input logic [3:0] be);
    logic [31:0] r;
    r = o;
    for (int i = 0; i < 4; i++)
      if (be[i]) r[8*i +: 8] = d[8*i +: 8];
    return r;
  endfunction

  // Model: a write lands first, then every port reads the updated array.
  always @(posedge clk) begin : mdl_a
    logic [63:0] e;
    e = '0;
    if (!rst_n) clrA = 32;
    else if (clrA > 0) begin
      memA[32-clrA] = '0;
      clrA--;
    end else begin
      if (a.wr_en && a.wr_addr != 0)
        memA[a.wr_addr] = mrg(memA[a.wr_addr], a.wr_data, a.wr_be);
      for (int p = 0; p < 2; p++) begin
        if (a.rd_addr[p*5 +: 5] != 0)
          e[p*32 +: 32] = memA[a.rd_addr[p*5 +: 5]];
      end
      if (a.clear_req) clrA = 32;
    end
    qA.push_back({clrA > 0, e});
  end

  always @(posedge clk) begin : mdl_b
    logic [63:0] e;
    logic [31:0] t;
    e = '0;
    if (!rst_n) clrB = 8;
    else if (clrB > 0) begin
      memB[8-clrB] = '0;
      clrB--;
    end else begin
      if (b.wr_en && b.wr_addr != 0) begin
        t = mrg({16'b0, memB[b.wr_addr]}, {16'b0, b.wr_data},
                {2'b0, b.wr_be});
        memB[b.wr_addr] = t[15:0];
      end
      for (int p = 0; p < 4; p++) begin
        if (b.rd_addr[p*3 +: 3] != 0)
          e[p*16 +: 16] = memB[b.rd_addr[p*3 +: 3]];
      end
      if (b.clear_req) clrB = 8;
    end
    qB.push_back({clrB > 0, e});
  end

  always @(negedge clk) begin : mon_a
    logic [64:0] x;
    if (qA.size() > 0) begin
      x = qA.pop_front();
      n_cmp++;
      if ({a.busy, a.rd_data} !== x) begin
        n_bad++;
        $display("FAIL dut32 t=%0t got busy=%0b rd=%h want busy=%0b rd=%h",
                 $time, a.busy, a.rd_data, x[64], x[63:0]);
      end
    end
  end

  always @(negedge clk) begin : mon_b
    logic [64:0] x;
    if (qB.size() > 0) begin
      x = qB.pop_front();
      n_cmp++;
      if ({b.busy, b.rd_data} !== x) begin
        n_bad++;
        $display("FAIL dut16 t=%0t got busy=%0b rd=%h want busy=%0b rd=%h",
                 $time, b.busy, b.rd_data, x[64], x[63:0]);
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic drvA(input logic [4:0] r0, input logic [4:0] r1,
                      input logic we, input logic [4:0] wa,
                      input logic [31:0] wd, input logic [3:0] be,
                      input logic cr);
    a.rd_addr   = {r1, r0};
    a.wr_en     = we;
    a.wr_addr   = wa;
    a.wr_data   = wd;
    a.wr_be     = be;
    a.clear_req = cr;
  endtask

  task automatic drvB(input logic [11:0] ra, input logic we,
                      input logic [2:0] wa, input logic [15:0] wd,
                      input logic [1:0] be, input logic cr);
    b.rd_addr   = ra;
    b.wr_en     = we;
    b.wr_addr   = wa;
    b.wr_data   = wd;
    b.wr_be     = be;
    b.clear_req = cr;
  endtask

  task automatic rndA(input logic cr);
    drvA(5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
         1'($urandom), 5'($urandom_range(0, 7)), $urandom,
         4'($urandom), cr);
  endtask

  task automatic rndB(input logic cr);
    drvB(12'($urandom), 1'($urandom), 3'($urandom),
         16'($urandom), 2'($urandom), cr);
  endtask

  task automatic sweepA();
    for (int i = 0; i < 16; i++) begin
      drvA(5'(2*i), 5'(2*i+1), 1'b0, 5'd0, 32'd0, 4'h0, 1'b0);
      cyc(1);
    end
  endtask

  task automatic chk_rst();
    n_cmp++;
    if (a.busy !== 1'b1 || a.rd_data !== '0) begin
      n_bad++;
      $display("FAIL rst32 got busy=%0b rd=%h want busy=1 rd=0",
               a.busy, a.rd_data);
    end
    n_cmp++;
    if (b.busy !== 1'b1 || b.rd_data !== '0) begin
      n_bad++;
      $display("FAIL rst16 got busy=%0b rd=%h want busy=1 rd=0",
               b.busy, b.rd_data);
    end
  endtask

  initial begin
    drvA(0, 0, 0, 0, 0, 0, 0);
    drvB(0, 0, 0, 0, 0, 0);
    cyc(2);
    rst_n = 1'b1;
    // Writes while busy must vanish; small array gets its directed writes.
    for (int i = 0; i < 30; i++) begin
      drvA(5'(i), 5'd3, 1'b1, 5'd3, 32'hFFFF_FFFF, 4'hF, 1'b0);
      case (i)
        0, 1, 2, 3, 4, 5: drvB(0, 1, 3'd2, 16'hFFFF, 2'b11, 0);
        10: drvB(0, 1, 3'd1, 16'h0101, 2'b11, 0);
        11: drvB(0, 1, 3'd2, 16'h0202, 2'b11, 0);
        12: drvB(0, 1, 3'd3, 16'h0303, 2'b11, 0);
        default: drvB({3'd1, 3'd3, 3'd2, 3'd1}, 0, 0, 0, 0, 0);
      endcase
      cyc(1);
    end
    drvB(0, 0, 0, 0, 0, 0);
    sweepA();

    drvA(0, 0, 1, 5, 32'hDEAD_BEEF, 4'hF, 0); cyc(1);
    drvA(5, 5, 0, 0, 0, 0, 0);                cyc(1);
    drvA(0, 0, 1, 0, 32'h1234_5678, 4'hF, 0); cyc(1);
    drvA(0, 0, 0, 0, 0, 0, 0);                cyc(1);
    drvA(0, 0, 1, 7, 32'hAABB_CCDD, 4'hF, 0); cyc(1);
    drvA(7, 7, 1, 7, 32'h1122_3344, 4'b0101, 0); cyc(1);
    drvA(7, 0, 0, 0, 0, 0, 0);                cyc(1);

    for (int i = 1; i < 32; i++) begin
      drvA(5'(i), 5'(i-1), 1, 5'(i), 32'(i), 4'hF, 0);
      cyc(1);
    end
    drvA(3, 3, 0, 0, 0, 0, 1); cyc(1);
    for (int i = 0; i < 32; i++) begin
      drvA(3, 3, 1, 3, 32'hFFFF_FFFF, 4'hF, 0);
      cyc(1);
    end
    sweepA();

    for (int i = 0; i < 400; i++) begin
      rndA(1'($urandom_range(0, 63) == 0));
      rndB(1'($urandom_range(0, 63) == 0));
      cyc(1);
    end

    for (int i = 0; i < 40; i++) begin
      rndA(1'b1);
      rndB(1'b1);
      cyc(1);
    end
    for (int i = 0; i < 40; i++) begin
      rndA(1'b0);
      rndB(1'b0);
      cyc(1);
    end

    drvA(1, 2, 0, 0, 0, 0, 1);
    drvB(0, 0, 0, 0, 0, 1);
    cyc(1);
    drvA(1, 2, 0, 0, 0, 0, 0);
    drvB(0, 0, 0, 0, 0, 0);
    cyc(10);
    #1 rst_n = 1'b0;
    #1 chk_rst();
    cyc(2);
    rst_n = 1'b1;
    for (int i = 0; i < 40; i++) begin
      rndA(1'b0);
      rndB(1'b0);
      cyc(1);
    end
    sweepA();
    cyc(2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end
endmodule
